// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard unit: destination scoreboard, load-use stall, branch flush, and a stall counter.
// Define HAZARD_FWD_EN to enable operand forwarding; otherwise every RAW hazard stalls until writeback.
module pipe_hazard_unit #(
    parameter  int REG_AW   = 5,
    parameter  int NSTAGE   = 3,
    parameter  int LOAD_LAT = 1,
    localparam int FW       = $clog2(NSTAGE + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_wr_i,
    input  logic              id_load_i,
    input  logic              branch_taken_i,
    input  logic              perf_clr_i,
    output logic              stall_o,
    output logic              flush_o,
    output logic [FW-1:0]     fwd_a_o,
    output logic [FW-1:0]     fwd_b_o,
    output logic [31:0]       stall_cnt_o
);

    logic [NSTAGE-1:0] sb_valid_q, sb_valid_d;
    logic [NSTAGE-1:0] sb_load_q, sb_load_d;
    logic [REG_AW-1:0] sb_rd_q [NSTAGE];
    logic [REG_AW-1:0] sb_rd_d [NSTAGE];
    logic [31:0]       stall_cnt_q, stall_cnt_d;

    logic [NSTAGE-1:0] m1, m2;
    logic              stall_raw;
    logic [FW-1:0]     fwd_a_raw, fwd_b_raw;

    // Register x0 is hardwired, so a zero source address never creates a dependency.
    always_comb begin
        m1 = '0;
        m2 = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            m1[k] = id_rs1_used_i && sb_valid_q[k] && (sb_rd_q[k] == id_rs1_i) && (id_rs1_i != '0);
            m2[k] = id_rs2_used_i && sb_valid_q[k] && (sb_rd_q[k] == id_rs2_i) && (id_rs2_i != '0);
        end
    end

`ifdef HAZARD_FWD_EN
    always_comb begin
        stall_raw = 1'b0;
        fwd_a_raw = '0;
        fwd_b_raw = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            if ((k < LOAD_LAT) && sb_load_q[k] && (m1[k] || m2[k])) begin
                stall_raw = id_valid_i;
            end
        end
        // Scan oldest to youngest so the youngest producer overrides.
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (m1[k]) fwd_a_raw = FW'(k + 1);
            if (m2[k]) fwd_b_raw = FW'(k + 1);
        end
        if (!id_valid_i) begin
            fwd_a_raw = '0;
            fwd_b_raw = '0;
        end
    end
`else
    always_comb begin
        stall_raw = id_valid_i && (|(m1 | m2));
        fwd_a_raw = '0;
        fwd_b_raw = '0;
    end
`endif

    // The oldest entry's load bit is never consumed, and the stall-only build ignores load bits.
    logic unused_load;
    assign unused_load = ^{sb_load_q, ((LOAD_LAT > NSTAGE) ? 1'b1 : 1'b0)};

    assign stall_o     = rst_i & stall_raw;
    assign flush_o     = rst_i & branch_taken_i & id_valid_i & ~stall_raw;
    assign fwd_a_o     = rst_i ? fwd_a_raw : '0;
    assign fwd_b_o     = rst_i ? fwd_b_raw : '0;
    assign stall_cnt_o = stall_cnt_q;

    always_comb begin
        sb_valid_d    = '0;
        sb_load_d     = '0;
        sb_valid_d[0] = id_valid_i && id_wr_i && (id_rd_i != '0) && !stall_raw;
        sb_load_d[0]  = id_load_i;
        sb_rd_d[0]    = id_rd_i;
        for (int k = 1; k < NSTAGE; k++) begin
            sb_valid_d[k] = sb_valid_q[k-1];
            sb_load_d[k]  = sb_load_q[k-1];
            sb_rd_d[k]    = sb_rd_q[k-1];
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (perf_clr_i) begin
            stall_cnt_d = '0;
        end else if (stall_raw && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sb_valid_q  <= '0;
            sb_load_q   <= '0;
            stall_cnt_q <= '0;
            for (int k = 0; k < NSTAGE; k++) begin
                sb_rd_q[k] <= '0;
            end
        end else begin
            sb_valid_q  <= sb_valid_d;
            sb_load_q   <= sb_load_d;
            stall_cnt_q <= stall_cnt_d;
            for (int k = 0; k < NSTAGE; k++) begin
                sb_rd_q[k] <= sb_rd_d[k];
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit with hand-computed expectations for both build flavours.
// Inputs change 1 time unit after a rising edge; outputs are checked before the next edge.
module tb_pipe_hazard_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        id_valid_i;
    logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
    logic        id_rs1_used_i, id_rs2_used_i;
    logic        id_wr_i, id_load_i, branch_taken_i, perf_clr_i;
    logic        stall_o, flush_o;
    logic [1:0]  fwd_a_o, fwd_b_o;
    logic [31:0] stall_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_hazard_unit dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .id_valid_i     (id_valid_i),
        .id_rs1_i       (id_rs1_i),
        .id_rs2_i       (id_rs2_i),
        .id_rs1_used_i  (id_rs1_used_i),
        .id_rs2_used_i  (id_rs2_used_i),
        .id_rd_i        (id_rd_i),
        .id_wr_i        (id_wr_i),
        .id_load_i      (id_load_i),
        .branch_taken_i (branch_taken_i),
        .perf_clr_i     (perf_clr_i),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .fwd_a_o        (fwd_a_o),
        .fwd_b_o        (fwd_b_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        id_valid_i     = 1'b0;
        id_rs1_i       = '0;
        id_rs2_i       = '0;
        id_rs1_used_i  = 1'b0;
        id_rs2_used_i  = 1'b0;
        id_rd_i        = '0;
        id_wr_i        = 1'b0;
        id_load_i      = 1'b0;
        branch_taken_i = 1'b0;
        perf_clr_i     = 1'b0;
    endtask

    task automatic producer(input logic [4:0] rd, input logic ld);
        idle();
        id_valid_i = 1'b1;
        id_rd_i    = rd;
        id_wr_i    = 1'b1;
        id_load_i  = ld;
    endtask

    task automatic consumer(input logic [4:0] rs1, input logic u1,
                            input logic [4:0] rs2, input logic u2, input logic br);
        idle();
        id_valid_i     = 1'b1;
        id_rs1_i       = rs1;
        id_rs1_used_i  = u1;
        id_rs2_i       = rs2;
        id_rs2_used_i  = u2;
        branch_taken_i = br;
    endtask

    task automatic drain();
        idle();
        repeat (3) step();
    endtask

    // Load producer then a dependent consumer; returns in the consumer's first (stalled) cycle.
    task automatic stall_pair(input logic [4:0] rd);
        producer(rd, 1'b1);
        step();
        consumer(rd, 1'b1, 5'd0, 1'b0, 1'b0);
        #1;
    endtask

    initial begin
        idle();
        rst_i = 1'b0;
        id_valid_i = 1'b1;
        id_rs1_i = 5'd1;
        id_rs1_used_i = 1'b1;
        branch_taken_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_stall", stall_o, 0);
        check("rst_flush", flush_o, 0);
        check("rst_fwd_a", fwd_a_o, 0);
        check("rst_cnt", stall_cnt_o, 0);
        idle();
        rst_i = 1'b1;
        step();

`ifdef HAZARD_FWD_EN
        producer(5'd5, 1'b0);
        #1 check("alu_prod_stall", stall_o, 0);
        step();
        consumer(5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
        #1 check("alu_fwd_a_ex", fwd_a_o, 1);
        check("alu_no_stall", stall_o, 0);
        check("alu_fwd_b_rf", fwd_b_o, 0);
        step();
        consumer(5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
        #1 check("alu_fwd_a_mem", fwd_a_o, 2);
        drain();

        producer(5'd7, 1'b1);
        step();
        consumer(5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        #1 check("load_use_stall", stall_o, 1);
        step();
        #1 check("load_use_release", stall_o, 0);
        check("load_fwd_b", fwd_b_o, 2);
        check("load_cnt", stall_cnt_o, 1);
        drain();

        producer(5'd3, 1'b0);
        step();
        producer(5'd3, 1'b0);
        step();
        consumer(5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
        #1 check("youngest_wins", fwd_a_o, 1);
        id_valid_i = 1'b0;
        #1 check("fwd_invalid_id", fwd_a_o, 0);
        producer(5'd0, 1'b0);
        step();
        consumer(5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
        #1 check("rd0_fwd_a", fwd_a_o, 0);
        check("rd0_fwd_b", fwd_b_o, 0);
        drain();

        producer(5'd8, 1'b1);
        step();
        consumer(5'd8, 1'b1, 5'd0, 1'b0, 1'b1);
        #1 check("br_stalled_flush", flush_o, 0);
        check("br_stalled_stall", stall_o, 1);
        step();
        #1 check("br_resolved_flush", flush_o, 1);
        check("br_cnt", stall_cnt_o, 2);
        drain();
`else
        producer(5'd9, 1'b0);
        #1 check("prod_no_stall", stall_o, 0);
        step();
        consumer(5'd9, 1'b1, 5'd0, 1'b0, 1'b0);
        #1 check("raw_stall_1", stall_o, 1);
        check("raw_fwd_a", fwd_a_o, 0);
        check("raw_cnt_0", stall_cnt_o, 0);
        step();
        #1 check("raw_stall_2", stall_o, 1);
        check("raw_cnt_1", stall_cnt_o, 1);
        step();
        #1 check("raw_stall_3", stall_o, 1);
        check("raw_fwd_b", fwd_b_o, 0);
        step();
        #1 check("raw_release", stall_o, 0);
        check("raw_cnt_3", stall_cnt_o, 3);
        step();

        producer(5'd0, 1'b0);
        step();
        consumer(5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
        #1 check("rd0_no_stall", stall_o, 0);
        step();

        producer(5'd6, 1'b0);
        step();
        consumer(5'd6, 1'b0, 5'd1, 1'b1, 1'b0);
        #1 check("unused_src_no_stall", stall_o, 0);
        consumer(5'd6, 1'b1, 5'd0, 1'b0, 1'b0);
        id_valid_i = 1'b0;
        #1 check("invalid_id_no_stall", stall_o, 0);
        drain();

        producer(5'd4, 1'b0);
        step();
        consumer(5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
        #1 check("br_stalled_flush", flush_o, 0);
        check("br_stalled_stall", stall_o, 1);
        repeat (3) step();
        #1 check("br_resolved_flush", flush_o, 1);
        check("br_resolved_stall", stall_o, 0);
        check("br_cnt", stall_cnt_o, 6);
        drain();
`endif

        stall_pair(5'd10);
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        step();
        release dut.stall_cnt_q;
        drain();
        check("sat_preset", stall_cnt_o, 32'hFFFF_FFFF);
        stall_pair(5'd13);
        check("sat_stall", stall_o, 1);
        step();
        #1 check("sat_hold", stall_cnt_o, 32'hFFFF_FFFF);
        drain();
        stall_pair(5'd14);
        perf_clr_i = 1'b1;
        step();
        perf_clr_i = 1'b0;
        #1 check("clr_over_inc", stall_cnt_o, 0);
        drain();

        stall_pair(5'd15);
        step();
        drain();
        check("cnt_before_rst", stall_cnt_o, 1);
        stall_pair(5'd11);
        check("pre_rst_stall", stall_o, 1);
        rst_i = 1'b0;
        #1 check("rst_mid_stall", stall_o, 0);
        check("rst_mid_cnt", stall_cnt_o, 0);
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        #1 check("post_rst_empty", stall_o, 0);
        check("post_rst_fwd_a", fwd_a_o, 0);
        step();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
